param_fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that supersedes the fixed PC register, +4 adder and 32-byte instruction memory. It holds the PC and reads a configurable-depth, byte-addressed, little-endian instruction memory that is loaded through a program port. It delivers one instruction per cycle over a valid/ready handshake with backpressure. It also accepts a branch/jump redirect and flags misaligned or out-of-range PCs as a sticky fault.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/imem_bank.sv | 41 ++++
 rtl/param_fetch_unit.sv | 139 +++++++++++++
 tb/tb_param_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the parametrised instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  // A PC is aligned when it addresses the first byte of an instruction word.
  function automatic logic is_aligned(input logic [31:0] pc);
    return (pc & 32'(INSTR_BYTES - 1)) == 32'd0;
  endfunction

endpackage

// File: rtl/imem_bank.sv
// Byte-addressed instruction storage: word-wide program write port and a
// combinational little-endian word read that may start on any byte.
module imem_bank
  import fetch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 64
) (
  input  logic                                          clk,
  input  logic                                          we,
  input  logic [XLEN-1:0]                               waddr,
  input  logic [XLEN-1:0]                               wdata,
  input  logic [$clog2(DEPTH_WORDS*INSTR_BYTES)-1:0]    raddr,
  output logic [XLEN-1:0]                               rdata
);

  localparam int              AW        = $clog2(DEPTH_WORDS * INSTR_BYTES);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(DEPTH_WORDS * INSTR_BYTES);

  logic [7:0] mem [DEPTH_WORDS*INSTR_BYTES];
  logic       wr_in_range;

  // The full write address is range-checked so stray high bits never alias.
  assign wr_in_range = waddr < MEM_BYTES;

  // Word write, byte 0 of the word lands at the lowest address.
  always_ff @(posedge clk) begin
    if (we && wr_in_range) begin
      for (int b = 0; b < INSTR_BYTES; b++) begin
        mem[{waddr[AW-1:2], b[1:0]}] <= wdata[8*b +: 8];
      end
    end
  end

  // Little-endian word read; byte offsets wrap inside the array.
  always_comb begin
    rdata = {mem[raddr + AW'(3)], mem[raddr + AW'(2)],
             mem[raddr + AW'(1)], mem[raddr]};
  end

endmodule

// File: rtl/param_fetch_unit.sv
// Instruction-fetch stage: PC, fetch FSM, redirect/fault handling and a
// valid/ready output register in front of the instruction memory.
module param_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 64,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            prog_we,
  input  logic [XLEN-1:0] prog_addr,
  input  logic [XLEN-1:0] prog_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            instr_ready,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  localparam int              AW        = $clog2(DEPTH_WORDS * INSTR_BYTES);
  localparam logic [XLEN-1:0] MEM_BYTES = XLEN'(DEPTH_WORDS * INSTR_BYTES);

  function automatic logic in_range(input logic [XLEN-1:0] a);
    return a < MEM_BYTES;
  endfunction

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] rdata_p0;
  logic            advance, redirect_ok, pc_ok;
  logic            pc_load, fetch_en, valid_d, fault_set;
  logic [XLEN-1:0] pc_d, fault_pc_d;

  imem_bank #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_imem (
    .clk   (clk),
    .we    (prog_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_p0[AW-1:0]),
    .rdata (rdata_p0)
  );

  assign advance     = !instr_valid || instr_ready;
  assign redirect_ok = is_aligned(redirect_pc) && in_range(redirect_pc);
  assign pc_ok       = in_range(pc_p0);

  // State register; FAULT is only left through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= BOOT;
    else       state_q <= state_d;
  end

  // Next state: one idle boot cycle, then run until a bad target or fetch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:  state_d = RUN;
      RUN: begin
        if (redirect_valid ? !redirect_ok : (advance && !pc_ok)) state_d = FAULT;
      end
      FAULT: state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  // Datapath control: redirect beats fetch; a stalled consumer freezes everything.
  always_comb begin
    pc_load    = 1'b0;
    pc_d       = pc_p0;
    fetch_en   = 1'b0;
    valid_d    = instr_valid;
    fault_set  = 1'b0;
    fault_pc_d = pc_p0;
    unique case (state_q)
      BOOT: begin
        valid_d = 1'b0;
        if (redirect_valid) begin
          pc_load = 1'b1;
          pc_d    = redirect_pc;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (redirect_ok) begin
            pc_load = 1'b1;
            pc_d    = redirect_pc;
          end else begin
            fault_set  = 1'b1;
            fault_pc_d = redirect_pc;
          end
        end else if (advance) begin
          if (pc_ok) begin
            fetch_en = 1'b1;
            pc_load  = 1'b1;
            pc_d     = pc_p0 + XLEN'(INSTR_BYTES);
            valid_d  = 1'b1;
          end else begin
            fault_set = 1'b1;
            valid_d   = 1'b0;
          end
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  // ---- stage p0 -> p1: PC update, output register, sticky fault capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0       <= RESET_PC;
      instr_valid <= 1'b0;
      instr_data  <= '0;
      instr_pc    <= '0;
      fault       <= 1'b0;
      fault_pc    <= '0;
    end else begin
      instr_valid <= valid_d;
      if (pc_load) pc_p0 <= pc_d;
      if (fetch_en) begin
        instr_data <= rdata_p0;
        instr_pc   <= pc_p0;
      end
      if (fault_set) begin
        fault    <= 1'b1;
        fault_pc <= fault_pc_d;
      end
    end
  end

endmodule

// File: tb/tb_param_fetch_unit.sv
// Scoreboard bench for param_fetch_unit: the stimulus queues the program-order
// instruction stream, a monitor pops one entry per accepted transfer.
module tb_param_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        prog_we = 1'b0;
  logic [31:0] prog_addr = '0, prog_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_ready = 1'b0;
  logic        instr_valid, fault;
  logic [31:0] instr_data, instr_pc, fault_pc;

  logic        b_reset = 1'b1;
  logic        b_prog_we = 1'b0;
  logic [31:0] b_prog_addr = '0, b_prog_data = '0;
  logic        b_valid, b_fault;
  logic [31:0] b_data, b_pc, b_fault_pc;

  always #5 clk = ~clk;

  param_fetch_unit #(.XLEN(32), .DEPTH_WORDS(64), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .fault(fault), .fault_pc(fault_pc)
  );

  param_fetch_unit #(.XLEN(32), .DEPTH_WORDS(4), .RESET_PC(32'h0)) dut_small (
    .clk(clk), .reset(b_reset), .prog_we(b_prog_we), .prog_addr(b_prog_addr),
    .prog_data(b_prog_data), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .instr_ready(1'b1), .instr_valid(b_valid), .instr_data(b_data),
    .instr_pc(b_pc), .fault(b_fault), .fault_pc(b_fault_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  m_mem [256];
  logic [31:0] b_words [4];
  int          total = 0, bad = 0;
  int          acc_count = 0;
  logic [31:0] last_acc_pc = '1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input int a);
    return {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
  endfunction

  // Program order from a start address to the end of the 64-word memory.
  task automatic sb_restart(input int start);
    exp_q.delete();
    for (int a = start; a < 256; a += 4) exp_q.push_back('{pc: 32'(a), data: model_word(a)});
  endtask

  task automatic prog_a(input logic [31:0] addr, input logic [31:0] data);
    prog_we = 1'b1; prog_addr = addr; prog_data = data;
    @(posedge clk); #1;
    prog_we = 1'b0;
    if (addr < 256) for (int b = 0; b < 4; b++) m_mem[{addr[7:2], 2'b00} + b] = data[8*b +: 8];
  endtask

  task automatic prog_b(input logic [31:0] addr, input logic [31:0] data);
    b_prog_we = 1'b1; b_prog_addr = addr; b_prog_data = data;
    @(posedge clk); #1;
    b_prog_we = 1'b0;
    if (addr < 16) b_words[addr[3:2]] = data;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_valid = 1'b1; redirect_pc = t;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    sb_restart(int'(t));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic monitor();
    logic        stall_prev = 1'b0, redir_prev = 1'b0;
    logic [31:0] prev_pc = '0, prev_data = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev && !redir_prev) begin
          check("hold_valid", {31'b0, instr_valid}, 32'd1);
          check("hold_pc", instr_pc, prev_pc);
          check("hold_data", instr_data, prev_data);
        end
        if (instr_valid && instr_ready) begin
          acc_count++;
          last_acc_pc = instr_pc;
          if (exp_q.size() == 0) begin
            check("unexpected_transfer_pc", instr_pc, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check("stream_pc", instr_pc, e.pc);
            check("stream_data", instr_data, e.data);
          end
        end
        stall_prev = instr_valid && !instr_ready;
        redir_prev = redirect_valid;
        prev_pc    = instr_pc;
        prev_data  = instr_data;
      end
    end
  endtask

  initial begin
    int n, cd, acc0;
    fork monitor(); join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_data", instr_data, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_fault_pc", fault_pc, 32'd0);

    // Program memory while held in reset
    for (int w = 0; w < 64; w++) begin
      logic [31:0] v;
      v = (w == 0) ? 32'h00940333 : (w == 1) ? 32'h413903b3 :
          (w == 2) ? 32'h035a02b3 : $urandom;
      prog_a(32'(w * 4), v);
    end

    // Release: first instruction two cycles later, then one per cycle
    instr_ready = 1'b1;
    sb_restart(0);
    reset = 1'b0;
    wait_valid(n);
    check("boot_latency", 32'(n), 32'd2);
    check("first_data", instr_data, 32'h00940333);

    // Backpressure while pc 4 is presented
    @(posedge clk); #1;
    check("bp_pc_before", instr_pc, 32'd4);
    instr_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_pc", instr_pc, 32'd4);
      check("bp_data", instr_data, 32'h413903b3);
    end
    instr_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_next_pc", instr_pc, 32'd8);
    check("bp_next_data", instr_data, 32'h035a02b3);

    // Redirect taken while pc 4 transfers
    redirect_to(32'h0);
    @(posedge clk); #1;
    check("re0_pc", instr_pc, 32'd0);
    @(posedge clk); #1;
    check("re0_pc4", instr_pc, 32'd4);
    redirect_to(32'h10);
    check("redir_accept_pc", last_acc_pc, 32'd4);
    check("redir_flush", {31'b0, instr_valid}, 32'd0);
    @(posedge clk); #1;
    check("redir_valid", {31'b0, instr_valid}, 32'd1);
    check("redir_pc", instr_pc, 32'h10);

    // Random ready and redirects, checked by the scoreboard
    acc0 = acc_count;
    cd = 5;
    for (int c = 0; c < 300; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if (cd == 0) begin
        redirect_to(32'($urandom_range(0, 31) * 4));
        cd = $urandom_range(6, 18);
      end else begin
        @(posedge clk); #1;
        cd--;
      end
    end
    check("random_progress", {31'b0, (acc_count - acc0) > 50}, 32'd1);

    // Misaligned redirect faults permanently
    instr_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h6;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    exp_q.delete();
    check("fault_set", {31'b0, fault}, 32'd1);
    check("fault_pc", fault_pc, 32'h6);
    check("fault_valid", {31'b0, instr_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    prog_a(32'h14, 32'hcafe_0bad);
    repeat (3) begin
      @(posedge clk); #1;
      check("fault_stuck_valid", {31'b0, instr_valid}, 32'd0);
    end
    check("fault_sticky", {31'b0, fault}, 32'd1);
    check("fault_pc_kept", fault_pc, 32'h6);
    #2 reset = 1'b1;
    #1;
    check("fault_cleared", {31'b0, fault}, 32'd0);
    check("fault_pc_cleared", fault_pc, 32'd0);
    @(posedge clk); #1;
    sb_restart(0);
    reset = 1'b0;
    wait_valid(n);
    check("post_fault_latency", 32'(n), 32'd2);

    // Asynchronous reset mid-stream at pc 8
    n = 0;
    while (!(instr_valid && instr_pc == 32'd8) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("reach_pc8", instr_pc, 32'd8);
    #1 reset = 1'b1;
    #1;
    check("async_valid", {31'b0, instr_valid}, 32'd0);
    check("async_data", instr_data, 32'd0);
    check("async_pc", instr_pc, 32'd0);
    @(posedge clk); #1;
    sb_restart(0);
    reset = 1'b0;
    wait_valid(n);
    check("restart_latency", 32'(n), 32'd2);
    check("restart_pc", instr_pc, 32'd0);
    check("restart_data", instr_data, model_word(0));
    repeat (8) @(posedge clk);
    #1;
    instr_ready = 1'b0;

    // Four-word memory runs off its end
    for (int w = 0; w < 4; w++) prog_b(32'(w * 4), $urandom);
    prog_b(32'h10, 32'hdead_beef);
    b_reset = 1'b0;
    n = 0;
    while (!b_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("small_latency", 32'(n), 32'd2);
    for (int w = 0; w < 4; w++) begin
      if (w != 0) begin
        @(posedge clk); #1;
      end
      check("small_pc", b_pc, 32'(w * 4));
      check("small_data", b_data, b_words[w]);
    end
    @(posedge clk); #1;
    check("small_fault", {31'b0, b_fault}, 32'd1);
    check("small_fault_pc", b_fault_pc, 32'h10);
    check("small_valid", {31'b0, b_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
